rf_writeback_unit: RTL and testbench



---
 rtl/rf_wb_pkg.sv | 29 ++
 rtl/wb_load_fifo.sv | 98 +++++++++
 rtl/rf_writeback_unit.sv | 140 ++++++++++++++
 tb/tb_rf_writeback_unit.sv | 466 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_pkg.sv
// Shared widths, request type and sizing helper for the register-file writeback block.
package rf_wb_pkg;

    localparam int unsigned WbAddrWidth     = 5;
    localparam int unsigned WbDataWidth     = 32;
    localparam int unsigned WbLoadFifoDepth = 4;

    // One pending register-file write.
    typedef struct packed {
        logic [WbAddrWidth-1:0] addr;
        logic [WbDataWidth-1:0] data;
    } wb_req_t;

    // Ceiling log2, never below 1 so it is always usable as a vector width.
    function automatic int unsigned wb_clog2(input int unsigned value);
        int unsigned result;
        result = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Occupancy counter width for the default load FIFO.
    localparam int unsigned WbCountWidth = wb_clog2(WbLoadFifoDepth + 1);

endpackage

// File: rtl/wb_load_fifo.sv
// Synchronous FIFO for load results, with a per-entry address match vector so the
// writeback arbiter can hold back younger ALU writes to the same register.
module wb_load_fifo
    import rf_wb_pkg::*;
#(
    parameter int unsigned Depth      = WbLoadFifoDepth,
    parameter int unsigned AddrWidth  = WbAddrWidth,
    parameter int unsigned DataWidth  = WbDataWidth,
    parameter int unsigned CountWidth = wb_clog2(Depth + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [AddrWidth-1:0]  push_addr,
    input  logic [DataWidth-1:0]  push_data,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output logic [CountWidth-1:0] count,
    output logic [AddrWidth-1:0]  head_addr,
    output logic [DataWidth-1:0]  head_data,
    input  logic [AddrWidth-1:0]  cmp_addr,
    output logic [Depth-1:0]      cmp_hit
);

    localparam int unsigned PtrWidth = wb_clog2(Depth);

    logic [AddrWidth-1:0]  addr_q [Depth];
    logic [DataWidth-1:0]  data_q [Depth];
    logic [Depth-1:0]      valid_q, valid_d;
    logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CountWidth-1:0] count_q, count_d;
    logic                  do_push, do_pop;

    // Status flags and guarded push/pop strobes.
    always_comb begin
        full    = (count_q == CountWidth'(Depth));
        empty   = (count_q == '0);
        do_push = push && !full;
        do_pop  = pop && !empty;
    end

    // Pointer, occupancy and entry-valid next state; pointers wrap as Depth is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        valid_d  = valid_q;
        count_d  = count_q;
        if (do_pop) begin
            rd_ptr_d          = rd_ptr_q + PtrWidth'(1);
            valid_d[rd_ptr_q] = 1'b0;
        end
        if (do_push) begin
            wr_ptr_d          = wr_ptr_q + PtrWidth'(1);
            valid_d[wr_ptr_q] = 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CountWidth'(1);
            2'b01:   count_d = count_q - CountWidth'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            valid_q  <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            valid_q  <= valid_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are qualified by valid_q so no reset is needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_q[wr_ptr_q] <= push_addr;
            data_q[wr_ptr_q] <= push_data;
        end
    end

    // Head view and per-entry destination compare.
    always_comb begin
        head_addr = addr_q[rd_ptr_q];
        head_data = data_q[rd_ptr_q];
        count     = count_q;
        for (int i = 0; i < int'(Depth); i++) begin
            cmp_hit[i] = valid_q[i] && (addr_q[i] == cmp_addr);
        end
    end

endmodule

// File: rtl/rf_writeback_unit.sv
// Register-file writeback initiator: merges unbuffered ALU results with buffered
// load results onto one registered write port and tracks outstanding writes.
module rf_writeback_unit
    import rf_wb_pkg::*;
#(
    parameter int unsigned AddrWidth     = WbAddrWidth,
    parameter int unsigned DataWidth     = WbDataWidth,
    parameter int unsigned NumRegs       = 2 ** AddrWidth,
    parameter int unsigned LoadFifoDepth = WbLoadFifoDepth
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   alu_valid,
    output logic                                   alu_ready,
    input  logic [AddrWidth-1:0]                   alu_addr,
    input  logic [DataWidth-1:0]                   alu_data,
    input  logic                                   ld_valid,
    output logic                                   ld_ready,
    input  logic [AddrWidth-1:0]                   ld_addr,
    input  logic [DataWidth-1:0]                   ld_data,
    input  logic                                   issue_valid,
    input  logic [AddrWidth-1:0]                   issue_addr,
    output logic                                   write_enable,
    output logic [AddrWidth-1:0]                   write_address,
    output logic [DataWidth-1:0]                   write_data,
    output logic [NumRegs-1:0]                     pending,
    output logic [wb_clog2(LoadFifoDepth + 1)-1:0] fifo_count
);

    localparam int unsigned CountWidth = wb_clog2(LoadFifoDepth + 1);

    logic                     fifo_full, fifo_empty;
    logic                     fifo_push, fifo_pop;
    logic [LoadFifoDepth-1:0] fifo_hit;
    logic [AddrWidth-1:0]     head_addr;
    logic [DataWidth-1:0]     head_data;
    logic                     alu_conflict, alu_fire, ld_fire, alu_write;

    logic                     write_enable_q, write_enable_d;
    logic [AddrWidth-1:0]     write_address_q, write_address_d;
    logic [DataWidth-1:0]     write_data_q, write_data_d;

    // Write retired on the port last cycle; its pending bit drops once the RF has it.
    logic                     clr_valid_q;
    logic [AddrWidth-1:0]     clr_addr_q;
    logic [NumRegs-1:0]       pending_q, pending_d;

    wb_load_fifo #(
        .Depth      (LoadFifoDepth),
        .AddrWidth  (AddrWidth),
        .DataWidth  (DataWidth),
        .CountWidth (CountWidth)
    ) u_load_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_addr (ld_addr),
        .push_data (ld_data),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head_addr (head_addr),
        .head_data (head_data),
        .cmp_addr  (alu_addr),
        .cmp_hit   (fifo_hit)
    );

    // Handshakes and arbitration: ALU first, FIFO head otherwise; x0 results are
    // accepted but never enqueued nor given a write slot.
    always_comb begin
        alu_conflict = |fifo_hit;
        ld_ready     = !fifo_full;
        // An older buffered load to the same register must retire first (WAW).
        alu_ready    = !fifo_full && !alu_conflict;
        alu_fire     = alu_valid && alu_ready;
        ld_fire      = ld_valid && ld_ready;
        alu_write    = alu_fire && (alu_addr != '0);
        fifo_push    = ld_fire && (ld_addr != '0);
        fifo_pop     = !alu_write && !fifo_empty;
    end

    // Next write-port contents; address and data hold while no write is issued.
    always_comb begin
        write_enable_d  = alu_write || fifo_pop;
        write_address_d = write_address_q;
        write_data_d    = write_data_q;
        if (alu_write) begin
            write_address_d = alu_addr;
            write_data_d    = alu_data;
        end else if (fifo_pop) begin
            write_address_d = head_addr;
            write_data_d    = head_data;
        end
    end

    // Registered write port.
    always_ff @(posedge clk) begin
        if (!rst) begin
            write_enable_q  <= 1'b0;
            write_address_q <= '0;
            write_data_q    <= '0;
        end else begin
            write_enable_q  <= write_enable_d;
            write_address_q <= write_address_d;
            write_data_q    <= write_data_d;
        end
    end

    // Scoreboard next state: clear the retired write, then apply a new issue so set wins.
    always_comb begin
        pending_d = pending_q;
        if (clr_valid_q) begin
            pending_d[clr_addr_q] = 1'b0;
        end
        if (issue_valid && (issue_addr != '0)) begin
            pending_d[issue_addr] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // Scoreboard register and one-cycle retire delay behind the write port.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pending_q   <= '0;
            clr_valid_q <= 1'b0;
            clr_addr_q  <= '0;
        end else begin
            pending_q   <= pending_d;
            clr_valid_q <= write_enable_q;
            clr_addr_q  <= write_address_q;
        end
    end

    assign write_enable  = write_enable_q;
    assign write_address = write_address_q;
    assign write_data    = write_data_q;
    assign pending       = pending_q;

endmodule

// File: tb/tb_rf_writeback_unit.sv
// Self-checking bench for rf_writeback_unit: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_rf_writeback_unit;
    import rf_wb_pkg::*;

    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 32;
    localparam int unsigned NR    = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          alu_valid, alu_ready, ld_valid, ld_ready, issue_valid;
    logic [AW-1:0] alu_addr, ld_addr, issue_addr, write_address;
    logic [DW-1:0] alu_data, ld_data, write_data;
    logic          write_enable;
    logic [NR-1:0] pending;
    logic [CW-1:0] fifo_count;

    always #5 clk = ~clk;

    rf_writeback_unit #(
        .AddrWidth     (AW),
        .DataWidth     (DW),
        .NumRegs       (NR),
        .LoadFifoDepth (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .alu_valid     (alu_valid),
        .alu_ready     (alu_ready),
        .alu_addr      (alu_addr),
        .alu_data      (alu_data),
        .ld_valid      (ld_valid),
        .ld_ready      (ld_ready),
        .ld_addr       (ld_addr),
        .ld_data       (ld_data),
        .issue_valid   (issue_valid),
        .issue_addr    (issue_addr),
        .write_enable  (write_enable),
        .write_address (write_address),
        .write_data    (write_data),
        .pending       (pending),
        .fifo_count    (fifo_count)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: buffered loads, scheduled scoreboard clears, current port value.
    typedef struct {
        logic [AW-1:0] addr;
        int            due;
    } clr_t;

    wb_req_t       fq[$];
    clr_t          clrs[$];
    logic          m_we;
    logic [AW-1:0] m_wa;
    logic [DW-1:0] m_wd;
    logic [NR-1:0] m_pend;
    int            cyc = 0;
    logic          exp_alu_rdy, exp_ld_rdy, obs_alu_rdy, obs_ld_rdy;

    task automatic set_idle();
        alu_valid   = 1'b0;
        ld_valid    = 1'b0;
        issue_valid = 1'b0;
        alu_addr    = '0;
        ld_addr     = '0;
        issue_addr  = '0;
        alu_data    = '0;
        ld_data     = '0;
    endtask

    // Advance one clock: sample readies, step the model, then sample just after the edge.
    task automatic tick();
        bit      conflict;
        logic    nwe;
        logic [AW-1:0] nwa;
        logic [DW-1:0] nwd;
        wb_req_t h, e;
        clr_t    c;
        #1;
        conflict = 1'b0;
        foreach (fq[i]) if (fq[i].addr == alu_addr) conflict = 1'b1;
        exp_ld_rdy  = (fq.size() != DEPTH);
        exp_alu_rdy = exp_ld_rdy && !conflict;
        obs_alu_rdy = alu_ready;
        obs_ld_rdy  = ld_ready;
        if (!rst) begin
            fq.delete();
            clrs.delete();
            m_we   = 1'b0;
            m_wa   = '0;
            m_wd   = '0;
            m_pend = '0;
        end else begin
            nwe = 1'b0;
            nwa = m_wa;
            nwd = m_wd;
            if (alu_valid && exp_alu_rdy && alu_addr != 0) begin
                nwe = 1'b1;
                nwa = alu_addr;
                nwd = alu_data;
            end else if (fq.size() != 0) begin
                h   = fq.pop_front();
                nwe = 1'b1;
                nwa = h.addr;
                nwd = h.data;
            end
            if (ld_valid && exp_ld_rdy && ld_addr != 0) begin
                e.addr = ld_addr;
                e.data = ld_data;
                fq.push_back(e);
            end
            foreach (clrs[i]) if (clrs[i].due == cyc) m_pend[clrs[i].addr] = 1'b0;
            while (clrs.size() != 0 && clrs[0].due <= cyc) void'(clrs.pop_front());
            if (issue_valid && issue_addr != 0) m_pend[issue_addr] = 1'b1;
            if (nwe) begin
                c.addr = nwa;
                c.due  = cyc + 2;
                clrs.push_back(c);
            end
            m_we = nwe;
            m_wa = nwa;
            m_wd = nwd;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            alu_valid   = 1'b1;
            alu_addr    = AW'($urandom_range(1, 31));
            alu_data    = $urandom;
            ld_valid    = 1'b1;
            ld_addr     = AW'($urandom_range(1, 31));
            ld_data     = $urandom;
            issue_valid = 1'b1;
            issue_addr  = AW'($urandom_range(1, 31));
            tick();
            checks++;
            if (write_enable !== 1'b0) begin
                failures++;
                $display("FAIL reset_we got=%0b exp=0", write_enable);
            end
            checks++;
            if (pending !== '0) begin
                failures++;
                $display("FAIL reset_pending got=%h exp=0", pending);
            end
            checks++;
            if (fifo_count !== '0) begin
                failures++;
                $display("FAIL reset_count got=%0d exp=0", fifo_count);
            end
            checks++;
            if (write_address !== '0 || write_data !== '0) begin
                failures++;
                $display("FAIL reset_port got=%0d/%h exp=0/0", write_address, write_data);
            end
        end
        rst         = 1'b1;
        issue_valid = 1'b0;
        ld_valid    = 1'b0;
        alu_addr    = 5'd17;
        alu_data    = 32'h1234_5678;
        tick();
        checks++;
        if (obs_alu_rdy !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_alu_ready got=%0b exp=1", obs_alu_rdy);
        end
        checks++;
        if (write_enable !== 1'b1 || write_address !== 5'd17 || write_data !== 32'h1234_5678) begin
            failures++;
            $display("FAIL post_reset_write got=%0b/%0d/%h exp=1/17/12345678",
                     write_enable, write_address, write_data);
        end
        set_idle();
        repeat (4) tick();
    endtask

    task automatic test_alu_only();
        issue_valid = 1'b1;
        issue_addr  = 5'd5;
        tick();
        issue_valid = 1'b0;
        alu_valid   = 1'b1;
        alu_addr    = 5'd5;
        alu_data    = 32'hDEAD_BEEF;
        tick();
        checks++;
        if (obs_alu_rdy !== 1'b1) begin
            failures++;
            $display("FAIL alu_ready got=%0b exp=1", obs_alu_rdy);
        end
        checks++;
        if (write_enable !== 1'b1 || write_address !== 5'd5 || write_data !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL alu_write got=%0b/%0d/%h exp=1/5/deadbeef",
                     write_enable, write_address, write_data);
        end
        checks++;
        if (pending[5] !== 1'b1) begin
            failures++;
            $display("FAIL alu_pend_n1 got=%0b exp=1", pending[5]);
        end
        set_idle();
        tick();
        checks++;
        if (write_enable !== 1'b0 || write_address !== 5'd5 || write_data !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL alu_hold got=%0b/%0d/%h exp=0/5/deadbeef",
                     write_enable, write_address, write_data);
        end
        checks++;
        if (pending[5] !== 1'b1) begin
            failures++;
            $display("FAIL alu_pend_n2 got=%0b exp=1", pending[5]);
        end
        tick();
        checks++;
        if (pending[5] !== 1'b0) begin
            failures++;
            $display("FAIL alu_pend_clear got=%0b exp=0", pending[5]);
        end
    endtask

    task automatic test_x0();
        alu_valid   = 1'b1;
        alu_addr    = '0;
        alu_data    = 32'hCAFE_0000;
        ld_valid    = 1'b1;
        ld_addr     = '0;
        ld_data     = 32'hCAFE_0001;
        issue_valid = 1'b1;
        issue_addr  = '0;
        tick();
        checks++;
        if (obs_alu_rdy !== 1'b1 || obs_ld_rdy !== 1'b1) begin
            failures++;
            $display("FAIL x0_ready got=%0b/%0b exp=1/1", obs_alu_rdy, obs_ld_rdy);
        end
        set_idle();
        tick();
        checks++;
        if (write_enable !== 1'b0) begin
            failures++;
            $display("FAIL x0_we got=%0b exp=0", write_enable);
        end
        checks++;
        if (fifo_count !== '0) begin
            failures++;
            $display("FAIL x0_count got=%0d exp=0", fifo_count);
        end
        checks++;
        if (pending[0] !== 1'b0 || write_address !== 5'd5) begin
            failures++;
            $display("FAIL x0_state got=%0b/%0d exp=0/5", pending[0], write_address);
        end
    endtask

    task automatic test_waw();
        ld_valid = 1'b1;
        ld_addr  = 5'd8;
        ld_data  = 32'hAAAA_0008;
        tick();
        checks++;
        if (fifo_count !== 3'd1) begin
            failures++;
            $display("FAIL waw_count got=%0d exp=1", fifo_count);
        end
        ld_valid  = 1'b0;
        alu_valid = 1'b1;
        alu_addr  = 5'd8;
        alu_data  = 32'hBBBB_0008;
        tick();
        checks++;
        if (obs_alu_rdy !== 1'b0) begin
            failures++;
            $display("FAIL waw_block got=%0b exp=0", obs_alu_rdy);
        end
        checks++;
        if (write_enable !== 1'b1 || write_address !== 5'd8 || write_data !== 32'hAAAA_0008) begin
            failures++;
            $display("FAIL waw_first got=%0b/%0d/%h exp=1/8/aaaa0008",
                     write_enable, write_address, write_data);
        end
        tick();
        checks++;
        if (obs_alu_rdy !== 1'b1) begin
            failures++;
            $display("FAIL waw_release got=%0b exp=1", obs_alu_rdy);
        end
        checks++;
        if (write_enable !== 1'b1 || write_address !== 5'd8 || write_data !== 32'hBBBB_0008) begin
            failures++;
            $display("FAIL waw_second got=%0b/%0d/%h exp=1/8/bbbb0008",
                     write_enable, write_address, write_data);
        end
        set_idle();
        repeat (3) tick();
    endtask

    task automatic test_contention();
        logic [AW-1:0] lds [4];
        logic [AW-1:0] got[$];
        int            n9;
        lds[0] = 5'd3;
        lds[1] = 5'd4;
        lds[2] = 5'd6;
        lds[3] = 5'd7;
        n9 = 0;
        alu_valid = 1'b1;
        alu_addr  = 5'd9;
        for (int k = 0; k < 4; k++) begin
            ld_valid = 1'b1;
            ld_addr  = lds[k];
            ld_data  = 32'h100 + k;
            alu_data = 32'h900 + k;
            tick();
            checks++;
            if (obs_ld_rdy !== 1'b1 || obs_alu_rdy !== 1'b1) begin
                failures++;
                $display("FAIL cont_fill_ready k=%0d got=%0b/%0b exp=1/1", k, obs_ld_rdy, obs_alu_rdy);
            end
            if (write_enable) begin
                if (write_address == 5'd9) n9++;
                else got.push_back(write_address);
            end
        end
        checks++;
        if (fifo_count !== 3'd4) begin
            failures++;
            $display("FAIL cont_full_count got=%0d exp=4", fifo_count);
        end
        ld_addr = 5'd10;
        tick();
        checks++;
        if (obs_ld_rdy !== 1'b0 || obs_alu_rdy !== 1'b0) begin
            failures++;
            $display("FAIL cont_full_ready got=%0b/%0b exp=0/0", obs_ld_rdy, obs_alu_rdy);
        end
        if (write_enable) begin
            if (write_address == 5'd9) n9++;
            else got.push_back(write_address);
        end
        ld_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            alu_valid = (k < 6);
            alu_data  = 32'hA00 + k;
            tick();
            if (write_enable) begin
                if (write_address == 5'd9) n9++;
                else got.push_back(write_address);
            end
        end
        set_idle();
        checks++;
        if (n9 != 10) begin
            failures++;
            $display("FAIL cont_alu_writes got=%0d exp=10", n9);
        end
        checks++;
        if (got.size() != 4) begin
            failures++;
            $display("FAIL cont_load_writes got=%0d exp=4", got.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (got[k] !== lds[k]) begin
                    failures++;
                    $display("FAIL cont_order k=%0d got=%0d exp=%0d", k, got[k], lds[k]);
                end
            end
        end
    endtask

    task automatic test_scoreboard_race();
        alu_valid = 1'b1;
        alu_addr  = 5'd12;
        alu_data  = 32'h0000_0C0C;
        tick();
        checks++;
        if (write_enable !== 1'b1 || write_address !== 5'd12) begin
            failures++;
            $display("FAIL race_write got=%0b/%0d exp=1/12", write_enable, write_address);
        end
        set_idle();
        tick();
        issue_valid = 1'b1;
        issue_addr  = 5'd12;
        tick();
        checks++;
        if (pending[12] !== 1'b1) begin
            failures++;
            $display("FAIL race_set_wins got=%0b exp=1", pending[12]);
        end
        set_idle();
        tick();
        checks++;
        if (pending[12] !== 1'b1) begin
            failures++;
            $display("FAIL race_sticky got=%0b exp=1", pending[12]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst         = !(i == 150 || i == 151);
            alu_valid   = ($urandom_range(0, 3) != 0);
            alu_addr    = AW'($urandom_range(0, 7));
            alu_data    = $urandom;
            ld_valid    = ($urandom_range(0, 1) != 0);
            ld_addr     = AW'($urandom_range(0, 7));
            ld_data     = $urandom;
            issue_valid = ($urandom_range(0, 2) == 0);
            issue_addr  = AW'($urandom_range(0, 15));
            tick();
            checks++;
            if (obs_alu_rdy !== exp_alu_rdy || obs_ld_rdy !== exp_ld_rdy) begin
                failures++;
                $display("FAIL rand_ready i=%0d got=%0b/%0b exp=%0b/%0b",
                         i, obs_alu_rdy, obs_ld_rdy, exp_alu_rdy, exp_ld_rdy);
            end
            checks++;
            if (write_enable !== m_we || write_address !== m_wa || write_data !== m_wd) begin
                failures++;
                $display("FAIL rand_port i=%0d got=%0b/%0d/%h exp=%0b/%0d/%h",
                         i, write_enable, write_address, write_data, m_we, m_wa, m_wd);
            end
            checks++;
            if (pending !== m_pend) begin
                failures++;
                $display("FAIL rand_pending i=%0d got=%h exp=%h", i, pending, m_pend);
            end
            checks++;
            if (fifo_count !== CW'(fq.size())) begin
                failures++;
                $display("FAIL rand_count i=%0d got=%0d exp=%0d", i, fifo_count, fq.size());
            end
        end
        set_idle();
    endtask

    initial begin
        set_idle();
        rst = 1'b0;
        test_reset();
        test_alu_only();
        test_x0();
        test_waw();
        test_contention();
        test_scoreboard_race();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
